spi_ram_master: RTL and testbench
=================================

Name: spi_ram_master

Overview:
- Host-side sequencer for the SPI-slave single-port-RAM wrapper.
- Accepts byte-wide read/write requests over a valid/ready interface and converts each into the required SPI frames on SS_n/MOSI, sharing clk with the slave.
- For reads, it captures the returned byte from MISO and presents it on a response port.
- Sits between system logic and the SPI_RAM wrapper; it is the only driver of SS_n and MOSI.

Parameters:
- GAP_CYC, 2: cycles SS_n is held high after every frame (min 1).
- RD_LAT, 2: cycles between the last MOSI bit of a read-data frame and MISO carrying rdata[7].
- ADDR_CACHE, 0: 1 skips the address frame when the target address equals the last address sent for that direction.

Ports:
- clk  in  1  system clock, shared with the slave
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master idle, can accept a request
- req_wr  in  1  1=write, 0=read
- req_addr  in  8  RAM address
- req_wdata  in  8  write data, ignored for reads
- rsp_valid  out  1  one-cycle pulse, rsp_rdata valid
- rsp_rdata  out  8  read byte, held until next read completes
- busy  out  1  equals ~req_ready
- SS_n  out  1  slave select, active low, registered
- MOSI  out  1  serial data to slave, registered
- MISO  in  1  serial data from slave

Behaviour:
- Reset (async, rst_n=0):
  - SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0.
  - Both address-cache valid flags cleared; FSM to IDLE.
  - Reset mid-frame aborts the frame immediately; SS_n goes high asynchronously.
- Accept: request is accepted on the edge where req_valid && req_ready. req_addr, req_wdata and req_wr are latched then; req_ready drops on that same edge.
- Frame format, 11 bits MSB first: {rw, type[1:0], payload[7:0]}.
  - Write address: rw=0, type=00.
  - Write data: rw=0, type=01.
  - Read address: rw=1, type=10.
  - Read data: rw=1, type=11, payload=8'h00.
- Frame timing, with cycle 1 = first cycle after the frame starts:
  - Cycle 1: lead cycle, SS_n=0, MOSI=0.
  - Cycles 2..12: the 11 bits on MOSI, one per cycle.
  - Then GAP_CYC cycles with SS_n=1, MOSI=0.
- Write op: write-address frame, then write-data frame. The next frame's lead cycle follows the gap directly.
- Read op: read-address frame, then read-data frame, with this extension:
  - After bit 12, SS_n stays low for RD_LAT+8 more cycles, MOSI=0.
  - MISO is sampled MSB first on the last 8 of those cycles.
  - rsp_rdata updates and rsp_valid pulses for 1 cycle on the cycle after the 8th sample, when SS_n returns high.
- FSM states and transitions:
  - IDLE -> LEAD -> SHIFT (11-bit counter) -> [RD_WAIT (RD_LAT) -> CAPTURE (8)] -> GAP (GAP_CYC).
  - From GAP: go to LEAD for the second frame, else IDLE.
  - req_ready reasserts in the first cycle after the final GAP.
- Latency from accept to req_ready high, GAP_CYC=2, no cache hit:
  - Write: 28 cycles.
  - Read: 38 cycles.
  - rsp_valid occurs 2 cycles before ready.
- Address cache (ADDR_CACHE=1):
  - Separate write-address and read-address registers, each with a valid flag.
  - On a hit, the address frame is omitted and the op starts with the data frame.
  - On a miss, the register is updated when that address frame completes.
  - ADDR_CACHE=0: the address frame is always sent.
- Requests arriving while busy are not accepted; req_valid must be held by the requester. Simultaneous completion and new req_valid is accepted the cycle after ready rises (no same-cycle bypass).
- MISO is ignored outside CAPTURE.

Test Plan:
- Reset mid write-data frame (rst_n low at bit 5) -> SS_n=1 and MOSI=0 immediately; req_ready=1 after release; next write starts with the address frame.
- Write addr=8'hFF, wdata=8'hFF -> MOSI frames 000_11111111 then 001_11111111, each preceded by 1 lead cycle and followed by 2 SS_n-high cycles; req_ready back after 28 cycles.
- Write addr=8'h3C, wdata=8'hA5, then read addr=8'h3C with the slave RAM model -> read frames 110_00111100 and 111_00000000; rsp_valid pulse with rsp_rdata=8'hA5 at cycle 36.
- Back-to-back: req_valid held high with two writes (8'h01/8'h11, 8'h02/8'h22) -> second accepted 1 cycle after ready; RAM[1]=8'h11, RAM[2]=8'h22; no overlap of SS_n-low periods.
- ADDR_CACHE=1: read 8'h10 twice -> second read emits only the read-data frame (latency 24); then write 8'h10 -> write-address frame still sent, since directions are cached separately.
- RD_LAT=4 build, read 8'h7E holding 8'hC3 -> SS_n low RD_LAT+8=12 cycles after bit 12; rsp_rdata=8'hC3.

Source files
------------

// File: rtl/spi_ram_master.sv
// Host-side SPI sequencer for the single-port-RAM slave wrapper: turns byte
// read/write requests into address/data frames on SS_n/MOSI and captures read bytes from MISO.
module spi_ram_master #(
  parameter int GAP_CYC    = 2,
  parameter int RD_LAT     = 2,
  parameter int ADDR_CACHE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CMAX = (RD_LAT > GAP_CYC) ? RD_LAT : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 12);

  localparam logic [CW-1:0] LAST_BIT  = CW'(10);
  localparam logic [CW-1:0] LAST_CAP  = CW'(7);
  localparam logic [CW-1:0] LAST_WAIT = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] LAST_GAP  = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_RD_WAIT,
    S_CAPTURE,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [10:0]   sh;
  logic [6:0]    cap;
  logic          op_wr;
  logic [7:0]    op_addr;
  logic [7:0]    op_wdata;
  logic          second;
  logic          addr_frame;
  logic          rd_frame;
  logic          wc_valid;
  logic [7:0]    wc_addr;
  logic          rc_valid;
  logic [7:0]    rc_addr;
  logic          hit;

  // {rw, type[1:0], payload}: writes use type 0x, reads 1x; the low type bit selects data.
  function automatic logic [10:0] build_frame(input logic wr, input logic data,
                                              input logic [7:0] addr, input logic [7:0] wdata);
    if (wr)
      return {1'b0, 1'b0, data, data ? wdata : addr};
    else
      return {1'b1, 1'b1, data, data ? 8'h00 : addr};
  endfunction

  always_comb begin
    hit = 1'b0;
    if (ADDR_CACHE != 0)
      hit = req_wr ? (wc_valid && (wc_addr == req_addr))
                   : (rc_valid && (rc_addr == req_addr));
  end

  assign busy = ~req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sh         <= '0;
      cap        <= '0;
      op_wr      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      second     <= 1'b0;
      addr_frame <= 1'b0;
      rd_frame   <= 1'b0;
      wc_valid   <= 1'b0;
      wc_addr    <= '0;
      rc_valid   <= 1'b0;
      rc_addr    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_wr      <= req_wr;
            op_addr    <= req_addr;
            op_wdata   <= req_wdata;
            req_ready  <= 1'b0;
            SS_n       <= 1'b0;
            MOSI       <= 1'b0;
            sh         <= build_frame(req_wr, hit, req_addr, req_wdata);
            second     <= ~hit;
            addr_frame <= ~hit;
            rd_frame   <= hit & ~req_wr;
            state      <= S_LEAD;
          end
        end
        S_LEAD: begin
          MOSI  <= sh[10];
          sh    <= {sh[9:0], 1'b0};
          cnt   <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == LAST_BIT) begin
            MOSI <= 1'b0;
            cnt  <= '0;
            if (addr_frame) begin
              if (op_wr) begin
                wc_valid <= 1'b1;
                wc_addr  <= op_addr;
              end else begin
                rc_valid <= 1'b1;
                rc_addr  <= op_addr;
              end
            end
            if (rd_frame) begin
              state <= (RD_LAT == 0) ? S_CAPTURE : S_RD_WAIT;
            end else begin
              SS_n  <= 1'b1;
              state <= S_GAP;
            end
          end else begin
            MOSI <= sh[10];
            sh   <= {sh[9:0], 1'b0};
            cnt  <= cnt + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (cnt == LAST_WAIT) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          cap <= {cap[5:0], MISO};
          if (cnt == LAST_CAP) begin
            rsp_rdata <= {cap, MISO};
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            cnt       <= '0;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == LAST_GAP) begin
            cnt <= '0;
            if (second) begin
              second     <= 1'b0;
              addr_frame <= 1'b0;
              rd_frame   <= ~op_wr;
              sh         <= build_frame(op_wr, 1'b1, op_addr, op_wdata);
              SS_n       <= 1'b0;
              state      <= S_LEAD;
            end else begin
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two builds (plain, and cached with longer read latency)
// driven against a frame-level SPI RAM slave and an operation-level reference model.
module tb_spi_ram_master;

  localparam int N = 2;

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction
  function automatic int rdl_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction
  function automatic int cache_of(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  typedef struct {
    int          inst;
    int          len;
    logic [10:0] frame;
  } fr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [N];
  logic       req_ready [N];
  logic       req_wr    [N];
  logic [7:0] req_addr  [N];
  logic [7:0] req_wdata [N];
  logic       rsp_valid [N];
  logic [7:0] rsp_rdata [N];
  logic       busy      [N];
  logic       ss_n      [N];
  logic       mosi      [N];
  logic       miso      [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_ram_master #(
      .GAP_CYC   (gap_of(g)),
      .RD_LAT    (rdl_of(g)),
      .ADDR_CACHE(cache_of(g))
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_wr   (req_wr[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .SS_n     (ss_n[g]),
      .MOSI     (mosi[g]),
      .MISO     (miso[g])
    );
  end

  // Slave side: frame decoder and RAM, one process for both builds.
  logic [7:0]  ram [N][256] = '{default: 8'h00};
  fr_t         flog [$];
  int          proto_err [N] = '{default: 0};
  int          s_cyc [N] = '{default: 0};
  int          s_hi  [N] = '{default: 100};
  logic [10:0] s_sh  [N];
  logic [7:0]  s_wa  [N];
  logic [7:0]  s_ra  [N];
  logic [7:0]  s_rb  [N];
  bit          s_rd  [N] = '{default: 1'b0};

  always @(negedge clk) begin
    fr_t fr;
    for (int i = 0; i < N; i++) begin
      if (ss_n[i] === 1'b0) begin
        if (s_cyc[i] == 0 && s_hi[i] < gap_of(i)) proto_err[i]++;
        s_cyc[i]++;
        s_hi[i] = 0;
        if (s_cyc[i] >= 2 && s_cyc[i] <= 12) s_sh[i] = {s_sh[i][9:0], mosi[i]};
        else if (mosi[i] !== 1'b0) proto_err[i]++;
        if (s_cyc[i] == 12) begin
          case (s_sh[i][10:8])
            3'b000:  s_wa[i] = s_sh[i][7:0];
            3'b001:  ram[i][s_wa[i]] = s_sh[i][7:0];
            3'b110:  s_ra[i] = s_sh[i][7:0];
            3'b111:  begin s_rb[i] = ram[i][s_ra[i]]; s_rd[i] = 1'b1; end
            default: proto_err[i]++;
          endcase
        end
        if (s_rd[i] && s_cyc[i] >= 13 + rdl_of(i) && s_cyc[i] <= 20 + rdl_of(i))
          miso[i] = s_rb[i][7 - (s_cyc[i] - 13 - rdl_of(i))];
        else
          miso[i] = 1'($urandom);
      end else begin
        if (s_cyc[i] != 0) begin
          fr.inst  = i;
          fr.len   = s_cyc[i];
          fr.frame = s_sh[i];
          flog.push_back(fr);
          s_cyc[i] = 0;
          s_rd[i]  = 1'b0;
        end
        if (mosi[i] !== 1'b0) proto_err[i]++;
        s_hi[i]++;
        miso[i] = 1'($urandom);
      end
    end
  end

  // Reference model: per-build RAM image, per-direction address caches, expected frames.
  logic [7:0] mram [N][256] = '{default: 8'h00};
  bit         mwc_v [N];
  logic [7:0] mwc_a [N];
  bit         mrc_v [N];
  logic [7:0] mrc_a [N];
  logic [7:0] last_rd [N];
  fr_t        exp_q [$];

  int checks = 0;
  int errors = 0;
  int last_wait, last_lat;
  logic       nxt_wr;
  logic [7:0] nxt_a, nxt_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd);
    bit  hit;
    fr_t f;
    exp_q.delete();
    f.inst = i;
    if (wr) hit = cache_of(i) != 0 && mwc_v[i] && mwc_a[i] == a;
    else    hit = cache_of(i) != 0 && mrc_v[i] && mrc_a[i] == a;
    if (!hit) begin
      f.len   = 12;
      f.frame = wr ? {3'b000, a} : {3'b110, a};
      exp_q.push_back(f);
      if (wr) begin mwc_v[i] = 1; mwc_a[i] = a; end
      else    begin mrc_v[i] = 1; mrc_a[i] = a; end
    end
    f.len   = wr ? 12 : 20 + rdl_of(i);
    f.frame = wr ? {3'b001, d} : {3'b111, 8'h00};
    exp_q.push_back(f);
    if (wr) mram[i][a] = d;
    rd  = mram[i][a];
    lat = 0;
    foreach (exp_q[k]) lat += exp_q[k].len + gap_of(i);
  endtask

  task automatic do_op(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input bit hold);
    int         exp_lat, n, w, base, perr0, rsp_cnt, rsp_edge;
    logic [7:0] exp_rd, rsp_data;
    base  = flog.size();
    perr0 = proto_err[i];
    model(i, wr, a, d, exp_lat, exp_rd);
    w = 0;
    while (req_ready[i] !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    check("ready_wait", (w < 100) ? 32'd1 : 32'd0, 1);
    req_wr[i] = wr; req_addr[i] = a; req_wdata[i] = d; req_valid[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_drop", req_ready[i], 0);
    check("busy", busy[i], 1);
    check("lead_ss", ss_n[i], 0);
    if (hold) begin
      req_wr[i] = nxt_wr; req_addr[i] = nxt_a; req_wdata[i] = nxt_d;
    end else begin
      req_valid[i] = 1'b0;
    end
    n = 0; rsp_cnt = 0; rsp_edge = -1; rsp_data = 'x;
    while (req_ready[i] !== 1'b1 && n < 200) begin
      if (rsp_valid[i] === 1'b1) begin
        rsp_cnt++;
        rsp_edge = n;
        rsp_data = rsp_rdata[i];
      end
      @(negedge clk);
      n++;
    end
    last_lat = n;
    check("latency", n, exp_lat);
    check("ss_at_ready", ss_n[i], 1);
    check("rsp_count", rsp_cnt, wr ? 0 : 1);
    if (!wr) begin
      last_rd[i] = exp_rd;
      check("rsp_edge", rsp_edge, exp_lat - gap_of(i));
      check("rsp_data", rsp_data, exp_rd);
    end
    check("rsp_hold", rsp_rdata[i], last_rd[i]);
    check("frame_count", flog.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < flog.size()) begin
        check($sformatf("frame%0d_bits", k), flog[base + k].frame, exp_q[k].frame);
        check($sformatf("frame%0d_len", k), flog[base + k].len, exp_q[k].len);
        check($sformatf("frame%0d_inst", k), flog[base + k].inst, i);
      end
    end
    check("protocol", proto_err[i], perr0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      mwc_v[i] = 0; mrc_v[i] = 0; last_rd[i] = 8'h00;
    end
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ss%0d", i), ss_n[i], 1);
      check($sformatf("rst_mosi%0d", i), mosi[i], 0);
      check($sformatf("rst_ready%0d", i), req_ready[i], 1);
      check($sformatf("rst_busy%0d", i), busy[i], 0);
      check($sformatf("rst_rspv%0d", i), rsp_valid[i], 0);
      check($sformatf("rst_rdata%0d", i), rsp_rdata[i], 0);
    end
  endtask

  initial begin
    logic       rw;
    logic [7:0] ra, rd;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Plain build: directed writes/reads, back-to-back, then random traffic.
    do_op(0, 1'b1, 8'hFF, 8'hFF, 1'b0);
    do_op(0, 1'b1, 8'h3C, 8'hA5, 1'b0);
    do_op(0, 1'b0, 8'h3C, 8'h5E, 1'b0);
    nxt_wr = 1'b1; nxt_a = 8'h02; nxt_d = 8'h22;
    do_op(0, 1'b1, 8'h01, 8'h11, 1'b1);
    do_op(0, 1'b1, 8'h02, 8'h22, 1'b0);
    check("b2b_accept_wait", last_wait, 0);
    check("b2b_ram1", ram[0][1], 8'h11);
    check("b2b_ram2", ram[0][2], 8'h22);
    for (int k = 0; k < 20; k++) begin
      rw = 1'($urandom); ra = 8'($urandom_range(0, 7)); rd = 8'($urandom);
      do_op(0, rw, ra, rd, 1'b0);
    end

    // Cached build with longer read latency and gap.
    do_op(1, 1'b1, 8'h7E, 8'hC3, 1'b0);
    do_op(1, 1'b0, 8'h7E, 8'h00, 1'b0);
    do_op(1, 1'b0, 8'h10, 8'h00, 1'b0);
    do_op(1, 1'b0, 8'h10, 8'h00, 1'b0);
    do_op(1, 1'b1, 8'h10, 8'h5A, 1'b0);
    do_op(1, 1'b1, 8'h10, 8'h6B, 1'b0);
    for (int k = 0; k < 20; k++) begin
      rw = 1'($urandom); ra = 8'($urandom_range(0, 3)); rd = 8'($urandom);
      do_op(1, rw, ra, rd, 1'b0);
    end

    // Reset during bit 5 of a write-data frame.
    req_wr[0] = 1'b1; req_addr[0] = 8'h44; req_wdata[0] = 8'hE6; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("pre_rst_ss", ss_n[0], 0);
    check("pre_rst_mosi", mosi[0], 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    check("post_rst_ready", req_ready[0], 1);
    check("aborted_write", ram[0][8'h44], mram[0][8'h44]);
    do_op(1, 1'b1, 8'h10, 8'h77, 1'b0);
    do_op(0, 1'b1, 8'h3C, 8'h99, 1'b0);
    do_op(0, 1'b0, 8'h3C, 8'h00, 1'b0);
    do_op(1, 1'b0, 8'h10, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
